chrisruk_digit_queue: RTL and testbench
=======================================

Name: chrisruk_digit_queue

Overview:
- Upstream feeder for the LED matrix scroller.
- Deserialises digit codes from a slow 3-wire serial input (ser_clk, ser_data, ser_frame) and buffers them in a small FIFO.
- Presents the "next digit" to the scroller, which requests a new one at each letter boundary (shift wrap 7->0).
- Optional loop mode recirculates the buffered message so a short string scrolls forever.

Parameters:
- DIGIT_W, 1, width of one digit code (1 selects font 0/1; wider for larger font tables).
- DEPTH, 4, FIFO entries; power of two, >=2.
- LOOP, 0, 1 = each popped digit is re-appended to the FIFO tail.
- BLANK, 0, digit value presented after reset until the first pop.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ser_clk  in  1  serial bit clock, asynchronous, slow (>=3 clk per half period)
- ser_data  in  1  serial data, MSB first, valid at ser_clk rising edge
- ser_frame  in  1  high = word in progress; low clears the bit counter
- next_req  in  1  single-cycle pulse from scroller: advance to next digit
- digit  out  DIGIT_W  current digit for scroller
- digit_valid  out  1  digit has been loaded from the FIFO at least once
- count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: a serial word was dropped
- underrun  out  1  one-cycle pulse: next_req while empty

Behaviour:
Reset (synchronous, clk, active-high):
- reset high at any clk edge, including mid-word or mid-pop, applies the reset values.
- Reset values: digit=BLANK, digit_valid=0, count=0, empty=1, full=0, overflow=0, underrun=0.
- Pointers, bit counter, shift register, pending register and synchronisers are cleared.

Input synchronisation and edge detect:
- ser_clk, ser_data and ser_frame each pass through a 2-FF synchroniser.
- A rising edge is detected when the synced ser_clk is 1 and its previous sample was 0.

Deserialiser:
- Synced ser_frame low: bit counter <= 0; no shift.
- Rising edge with frame high: shreg <= {shreg, data}; bit counter increments.
- The edge that completes DIGIT_W bits raises word_rdy and resets the counter to 0.
- Latency: pin edge of the last bit -> count visible incremented = 4 clk.

FIFO write arbitration (single write port):
- Sources, priority high to low: loop re-push, pending word, new word_rdy.
- A serial word that cannot write this cycle goes to a 1-entry pending register and is written on the next free cycle.
- A serial word that arrives when the FIFO, including pending reservation, is full is discarded and sets overflow; overflow clears only on reset.
- A loop re-push never overflows, because it follows its own pop.

Pop (next_req):
- count>0: digit <= head, rd_ptr++, digit_valid <= 1.
- LOOP=1: the same value is written at wr_ptr and wr_ptr++, so count is unchanged.
- count==0: digit and digit_valid hold; underrun=1 for one cycle.
- digit updates on the clk edge after next_req, giving 1-cycle latency.

Count and flags:
- Simultaneous serial push and pop (LOOP=0): count unchanged, both take effect.
- full and empty are registered and consistent with count in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- next_req asserted for consecutive cycles gives one pop per cycle.

Test Plan:
- Reset: assert reset 2 clk -> digit=0, digit_valid=0, count=0, empty=1, overflow=0.
- Serial load, DIGIT_W=1: send words 1,0,1 (ser_clk half period 4 clk, frame high per word) -> count=3 four clk after each last edge; next_req x3 -> digit 1,0,1, digit_valid=1 after first pop.
- Framing: send one bit, drop ser_frame, then send full word 1 -> only value 1 is pushed, count=1.
- Overflow, DEPTH=4: push 5 words, no pops -> count=4, full=1, overflow=1; pops return the first 4 words in order; overflow stays 1 until reset.
- Underrun: next_req with count=0 after one pop -> underrun pulse 1 cycle, digit holds its last value, count stays 0.
- Loop, LOOP=1: load 1,0, then 6 pops -> digit 1,0,1,0,1,0 with count=2 throughout; a word arriving on a pop cycle goes to pending, and count=3 two cycles later.
- Reset mid-word: reset after 3 of DIGIT_W=4 bits -> no push; the next 4-bit word is received intact.

Source files
------------

// File: rtl/chrisruk_digit_queue_if.sv
// ---------------------------------------------------------------------------
// chrisruk_digit_queue_if
//   Bundles the serial input pins and the scroller-facing digit/status signals
//   of chrisruk_digit_queue.
//   master : drives the serial pins and next_req (feeder / testbench side)
//   slave  : the digit queue itself
// Signals:
//   ser_clk, ser_data, ser_frame  3-wire serial input (asynchronous, slow)
//   next_req                      single-cycle advance request from scroller
//   digit, digit_valid            current digit and "loaded at least once"
//   count, full, empty            FIFO occupancy and registered flags
//   overflow                      sticky: a serial word was dropped
//   underrun                      one-cycle pulse: next_req while empty
// ---------------------------------------------------------------------------
interface chrisruk_digit_queue_if #(
  parameter int DIGIT_W = 1,
  parameter int DEPTH   = 4
);
  logic                     ser_clk;
  logic                     ser_data;
  logic                     ser_frame;
  logic                     next_req;
  logic [DIGIT_W-1:0]       digit;
  logic                     digit_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     underrun;

  modport master (
    output ser_clk, ser_data, ser_frame, next_req,
    input  digit, digit_valid, count, full, empty, overflow, underrun
  );

  modport slave (
    input  ser_clk, ser_data, ser_frame, next_req,
    output digit, digit_valid, count, full, empty, overflow, underrun
  );
endinterface

// File: rtl/chrisruk_digit_queue.sv
// ---------------------------------------------------------------------------
// chrisruk_digit_queue
//   Upstream feeder for the LED matrix scroller. Deserialises digit codes from
//   a slow 3-wire serial input, buffers them in a DEPTH-entry FIFO and presents
//   the next digit on each next_req. With LOOP=1 every popped digit is written
//   back to the tail so a short message recirculates forever.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    chrisruk_digit_queue_if.slave (serial pins, next_req, digit/status)
// ---------------------------------------------------------------------------
module chrisruk_digit_queue #(
  parameter int                 DIGIT_W = 1,
  parameter int                 DEPTH   = 4,
  parameter int                 LOOP    = 0,
  parameter logic [DIGIT_W-1:0] BLANK   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  chrisruk_digit_queue_if.slave   bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;

  // Synchronisers: bit [1] is the synchronised value.
  logic [1:0]         sclk_q, sdata_q, sframe_q;
  logic               sclk_prev_q;
  logic               rise;

  // Deserialiser
  logic [DIGIT_W-1:0] shreg_q;
  logic [BCW-1:0]     bitcnt_q;
  logic               word_rdy_q;
  logic [DIGIT_W-1:0] shift_w;

  // FIFO state
  logic [DIGIT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, empty_q;
  logic               pend_vld_q, pend_vld_d;
  logic [DIGIT_W-1:0] pend_q, pend_d;
  logic               overflow_q, underrun_q;
  logic [DIGIT_W-1:0] digit_q;
  logic               digit_valid_q;

  // Write arbitration
  logic               pop, loop_push, pend_drain, drop, accept, direct, wr_en;
  logic [DIGIT_W-1:0] wr_data;
  int                 occ;

  assign rise    = sclk_q[1] & ~sclk_prev_q;
  assign shift_w = DIGIT_W'({shreg_q, sdata_q[1]});

  // ---------------- synchronisers + deserialiser ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q      <= '0;
      sdata_q     <= '0;
      sframe_q    <= '0;
      sclk_prev_q <= 1'b0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      word_rdy_q  <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[0],   bus.ser_clk};
      sdata_q     <= {sdata_q[0],  bus.ser_data};
      sframe_q    <= {sframe_q[0], bus.ser_frame};
      sclk_prev_q <= sclk_q[1];
      word_rdy_q  <= 1'b0;
      if (!sframe_q[1]) begin
        bitcnt_q <= '0;
      end else if (rise) begin
        shreg_q <= shift_w;
        if (bitcnt_q == BCW'(DIGIT_W - 1)) begin
          // shreg_q holds the complete word while word_rdy_q is high; the next
          // serial edge is many clk away, so no separate word register.
          bitcnt_q   <= '0;
          word_rdy_q <= 1'b1;
        end else begin
          bitcnt_q <= bitcnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------- FIFO write arbitration ----------------
  // NOTE: every signal assigned here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    pop        = bus.next_req && (count_q != '0);
    loop_push  = (LOOP != 0) && pop;
    pend_drain = pend_vld_q && !loop_push;
    // Occupancy including the pending reservation, minus a slot freed by a
    // non-loop pop in this same cycle.
    occ        = int'(count_q) + int'(pend_vld_q) - (((LOOP == 0) && pop) ? 1 : 0);
    // A second waiting word has nowhere to go if pending cannot drain.
    drop       = word_rdy_q && ((occ >= DEPTH) || (pend_vld_q && !pend_drain));
    accept     = word_rdy_q && !drop;
    direct     = accept && !loop_push && !pend_vld_q;
    wr_en      = loop_push || pend_drain || direct;
    if (loop_push)       wr_data = mem_q[rd_ptr_q];
    else if (pend_vld_q) wr_data = pend_q;
    else                 wr_data = shreg_q;
    pend_vld_d = (pend_vld_q && !pend_drain) || (accept && !direct);
    pend_d     = (accept && !direct) ? shreg_q : pend_q;
    count_d    = count_q + CW'(wr_en) - CW'(pop);
  end

  // NOTE: the storage array carries no reset; only pointers and count define
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      pend_vld_q    <= 1'b0;
      pend_q        <= '0;
      overflow_q    <= 1'b0;
      underrun_q    <= 1'b0;
      digit_q       <= BLANK;
      digit_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_q + PW'(pop);
      wr_ptr_q   <= wr_ptr_q + PW'(wr_en);
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_q | drop;
      underrun_q <= bus.next_req && (count_q == '0);
      if (pop) begin
        digit_q       <= mem_q[rd_ptr_q];
        digit_valid_q <= 1'b1;
      end
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.overflow    = overflow_q;
  assign bus.underrun    = underrun_q;
endmodule

// File: tb/tb_chrisruk_digit_queue.sv
// ---------------------------------------------------------------------------
// tb_chrisruk_digit_queue
//   Directed bench for chrisruk_digit_queue. Three instances share clk/reset:
//     dut0: DIGIT_W=1, DEPTH=4, LOOP=0   (load, pop, underrun, overflow)
//     dut1: DIGIT_W=1, DEPTH=4, LOOP=1   (recirculation, pending register)
//     dut2: DIGIT_W=4, DEPTH=4, LOOP=0   (framing, reset mid-word)
//   Inputs change on the falling clk edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_chrisruk_digit_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sc [3];
  logic sd [3];
  logic sf [3];
  logic nr [3];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  chrisruk_digit_queue_if #(.DIGIT_W(1), .DEPTH(4)) if0 ();
  chrisruk_digit_queue_if #(.DIGIT_W(1), .DEPTH(4)) if1 ();
  chrisruk_digit_queue_if #(.DIGIT_W(4), .DEPTH(4)) if2 ();

  assign if0.ser_clk = sc[0]; assign if0.ser_data = sd[0];
  assign if0.ser_frame = sf[0]; assign if0.next_req = nr[0];
  assign if1.ser_clk = sc[1]; assign if1.ser_data = sd[1];
  assign if1.ser_frame = sf[1]; assign if1.next_req = nr[1];
  assign if2.ser_clk = sc[2]; assign if2.ser_data = sd[2];
  assign if2.ser_frame = sf[2]; assign if2.next_req = nr[2];

  chrisruk_digit_queue #(.DIGIT_W(1), .DEPTH(4), .LOOP(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  chrisruk_digit_queue #(.DIGIT_W(1), .DEPTH(4), .LOOP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  chrisruk_digit_queue #(.DIGIT_W(4), .DEPTH(4), .LOOP(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sc[i] = 1'b0; sd[i] = 1'b0; sf[i] = 1'b0; nr[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drops ser_clk, sets data and frame, then raises ser_clk 4 clk later.
  // Returns on the negedge at which ser_clk rose.
  task automatic ser_bit(input int id, input bit b);
    sc[id] = 1'b0; sd[id] = b; sf[id] = 1'b1;
    repeat (4) @(negedge clk);
    sc[id] = 1'b1;
  endtask

  task automatic ser_word(input int id, input int val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_bit(id, val[i]);
      repeat (4) @(negedge clk);
    end
    sc[id] = 1'b0; sf[id] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop(input int id);
    nr[id] = 1'b1;
    @(negedge clk);
    nr[id] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int exp4 [4];
    exp4 = '{1, 0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      sc[i] = 1'b0; sd[i] = 1'b0; sf[i] = 1'b0; nr[i] = 1'b0;
    end

    // ---------------- reset values ----------------
    do_reset();
    check("rst_digit",    int'(if0.digit),       0);
    check("rst_valid",    int'(if0.digit_valid), 0);
    check("rst_count",    int'(if0.count),       0);
    check("rst_empty",    int'(if0.empty),       1);
    check("rst_full",     int'(if0.full),        0);
    check("rst_overflow", int'(if0.overflow),    0);
    check("rst_underrun", int'(if0.underrun),    0);
    check("rst_digit_w4", int'(if2.digit),       0);

    // ---------------- serial load 1,0,1 with latency ----------------
    ser_bit(0, 1'b1);
    repeat (3) @(negedge clk);
    check("lat_3clk_count", int'(if0.count), 0);
    @(negedge clk);
    check("lat_4clk_count", int'(if0.count), 1);
    check("lat_4clk_empty", int'(if0.empty), 0);
    sc[0] = 1'b0; sf[0] = 1'b0;
    repeat (4) @(negedge clk);
    ser_word(0, 0, 1);
    ser_word(0, 1, 1);
    check("load_count",     int'(if0.count),       3);
    check("load_valid_pre", int'(if0.digit_valid), 0);
    check("load_blank",     int'(if0.digit),       0);
    pop(0);
    check("pop1_digit", int'(if0.digit),       1);
    check("pop1_valid", int'(if0.digit_valid), 1);
    check("pop1_count", int'(if0.count),       2);
    pop(0);
    check("pop2_digit", int'(if0.digit), 0);
    pop(0);
    check("pop3_digit", int'(if0.digit), 1);
    check("pop3_count", int'(if0.count), 0);
    check("pop3_empty", int'(if0.empty), 1);

    // ---------------- underrun ----------------
    pop(0);
    check("unr_pulse", int'(if0.underrun), 1);
    check("unr_digit", int'(if0.digit),    1);
    check("unr_count", int'(if0.count),    0);
    @(negedge clk);
    check("unr_clear", int'(if0.underrun), 0);

    // ---------------- overflow ----------------
    do_reset();
    for (int i = 0; i < 4; i++) ser_word(0, exp4[i], 1);
    check("ovf_count4", int'(if0.count),    4);
    check("ovf_full",   int'(if0.full),     1);
    check("ovf_none",   int'(if0.overflow), 0);
    ser_word(0, 0, 1);
    check("ovf_count5", int'(if0.count),    4);
    check("ovf_set",    int'(if0.overflow), 1);
    // back-to-back pops, one per cycle
    nr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("ovf_pop%0d", i), int'(if0.digit), exp4[i]);
    end
    nr[0] = 1'b0;
    @(negedge clk);
    check("ovf_empty",  int'(if0.empty),    1);
    check("ovf_nfull",  int'(if0.full),     0);
    check("ovf_sticky", int'(if0.overflow), 1);
    pop(0);
    check("ovf_no5th",  int'(if0.underrun), 1);

    // ---------------- loop mode ----------------
    do_reset();
    check("rst_ovf_clr", int'(if0.overflow), 0);
    ser_word(1, 1, 1);
    ser_word(1, 0, 1);
    check("loop_count", int'(if1.count), 2);
    nr[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("loop_pop%0d", i),   int'(if1.digit), (i % 2 == 0) ? 1 : 0);
      check($sformatf("loop_count%0d", i), int'(if1.count), 2);
    end
    nr[1] = 1'b0;
    // word_rdy lands on the 4th clk after the edge; pop exactly then
    ser_bit(1, 1'b1);
    repeat (3) @(negedge clk);
    nr[1] = 1'b1;
    @(negedge clk);
    nr[1] = 1'b0;
    check("pend_digit",  int'(if1.digit), 1);
    check("pend_count2", int'(if1.count), 2);
    @(negedge clk);
    check("pend_count3", int'(if1.count), 3);
    sc[1] = 1'b0; sf[1] = 1'b0;
    repeat (4) @(negedge clk);
    pop(1);
    check("loop3_a", int'(if1.digit), 0);
    pop(1);
    check("loop3_b", int'(if1.digit), 1);
    pop(1);
    check("loop3_c", int'(if1.digit), 1);
    check("loop3_count", int'(if1.count), 3);

    // ---------------- framing (DIGIT_W=4) ----------------
    do_reset();
    ser_bit(2, 1'b1);
    repeat (4) @(negedge clk);
    sc[2] = 1'b0;
    repeat (4) @(negedge clk);
    sf[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("frm_partial", int'(if2.count), 0);
    ser_word(2, 1, 4);
    check("frm_count", int'(if2.count), 1);
    pop(2);
    check("frm_digit", int'(if2.digit), 1);

    // ---------------- reset mid-word ----------------
    for (int i = 0; i < 3; i++) begin
      ser_bit(2, 1'b1);
      repeat (4) @(negedge clk);
    end
    do_reset();
    check("mid_count", int'(if2.count), 0);
    check("mid_digit", int'(if2.digit), 0);
    ser_word(2, 6, 4);
    check("mid_word_count", int'(if2.count), 1);
    pop(2);
    check("mid_word_digit", int'(if2.digit), 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
